// File: rtl/uart_color_rx.sv
// 8N1 UART receiver with an ASCII '0'..'7' colour-command decoder.
// Bytes are sampled mid-bit from a 2-FF synchronised copy of uart_rx.
module uart_color_rx #(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [2:0] received_color,
  output logic       data_ready,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       cmd_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic [2:0]      color_q, color_d;
  logic            byte_valid_q, byte_valid_d;
  logic            data_ready_q, data_ready_d;
  logic            frame_err_q, frame_err_d;
  logic            cmd_err_q, cmd_err_d;
  logic            blocked_q, blocked_d;   // line still low after a framing error

  // NOTE: every clocked assignment uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      color_q      <= '0;
      byte_valid_q <= 1'b0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      color_q      <= color_d;
      byte_valid_q <= byte_valid_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
      cmd_err_q    <= cmd_err_d;
      blocked_q    <= blocked_d;
    end
  end

  // NOTE: defaults first so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    color_d      = color_q;
    blocked_d    = blocked_q;
    byte_valid_d = 1'b0;
    data_ready_d = 1'b0;
    frame_err_d  = 1'b0;
    cmd_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (rx_s_q) begin
          blocked_d = 1'b0;
        end else if (!blocked_q) begin
          state_d = START;
        end
      end
      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_s_q ? IDLE : DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          if (rx_s_q) begin
            rx_byte_d    = shift_q;
            byte_valid_d = 1'b1;
            // '0'..'7' are 8'h30..8'h37: upper five bits fixed at 5'b00110.
            if (shift_q[7:3] == 5'b00110) begin
              color_d      = shift_q[2:0];
              data_ready_d = 1'b1;
            end else begin
              cmd_err_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            blocked_d   = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign received_color = color_q;
  assign data_ready     = data_ready_q;
  assign rx_byte        = rx_byte_q;
  assign byte_valid     = byte_valid_q;
  assign frame_err      = frame_err_q;
  assign cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_uart_color_rx.sv
// Directed and randomised frames for uart_color_rx, checked against a
// byte-level model of what the receiver should report.
module tb_uart_color_rx;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [2:0] received_color;
  logic       data_ready;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       cmd_err;

  uart_color_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .received_color (received_color),
    .data_ready     (data_ready),
    .rx_byte        (rx_byte),
    .byte_valid     (byte_valid),
    .frame_err      (frame_err),
    .cmd_err        (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse monitor: counts pulses and checks their width and exclusivity.
  int cnt_bv = 0, cnt_dr = 0, cnt_ce = 0, cnt_fe = 0;
  logic prev_bv = 1'b0, prev_dr = 1'b0, prev_ce = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin
      cnt_bv++;
      check("bv_width", 32'(prev_bv), 32'd0);
      check("bv_decode", 32'(data_ready ^ cmd_err), 32'd1);
    end
    if (data_ready) begin
      cnt_dr++;
      check("dr_width", 32'(prev_dr), 32'd0);
      check("dr_vs_ce", 32'(cmd_err), 32'd0);
    end
    if (cmd_err) begin
      cnt_ce++;
      check("ce_width", 32'(prev_ce), 32'd0);
    end
    if (frame_err) begin
      cnt_fe++;
      check("fe_width", 32'(prev_fe), 32'd0);
      check("fe_vs_bv", 32'(byte_valid), 32'd0);
    end
    prev_bv = byte_valid;
    prev_dr = data_ready;
    prev_ce = cmd_err;
    prev_fe = frame_err;
  end

  // Reference model state.
  logic [2:0] exp_color = 3'd0;
  logic [7:0] exp_byte  = 8'h00;
  int exp_bv = 0, exp_dr = 0, exp_ce = 0, exp_fe = 0;

  function automatic bit is_cmd(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h37);
  endfunction

  task automatic hold_line(input logic val, input int n_clks);
    uart_rx = val;
    repeat (n_clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    hold_line(stop_bit, CPB);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rx_byte"}, 32'(rx_byte), 32'(exp_byte));
    check({tag, ".color"},   32'(received_color), 32'(exp_color));
    check({tag, ".n_bv"},    32'(cnt_bv), 32'(exp_bv));
    check({tag, ".n_dr"},    32'(cnt_dr), 32'(exp_dr));
    check({tag, ".n_ce"},    32'(cnt_ce), 32'(exp_ce));
    check({tag, ".n_fe"},    32'(cnt_fe), 32'(exp_fe));
  endtask

  // Send one frame, advance the model, and compare at the end of the stop bit.
  task automatic apply_frame(input string tag, input logic [7:0] b, input logic good_stop);
    send_frame(b, good_stop);
    if (good_stop) begin
      exp_byte = b;
      exp_bv++;
      if (is_cmd(b)) begin
        exp_color = b[2:0];
        exp_dr++;
      end else begin
        exp_ce++;
      end
    end else begin
      exp_fe++;
    end
    compare_all(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] order [256];
    int dr_before, ce_before, fe_before;

    // Reset state.
    repeat (3) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;
    hold_line(1'b1, 2 * CPB);

    // T1: '3'.
    apply_frame("t1", 8'h33, 1'b1);
    hold_line(1'b1, CPB);

    // T2: '7' then 'A' back-to-back.
    apply_frame("t2a", 8'h37, 1'b1);
    apply_frame("t2b", 8'h41, 1'b1);
    check("t2.color_held", 32'(received_color), 32'd7);
    hold_line(1'b1, CPB);

    // T3: '5' with a low stop bit.
    apply_frame("t3", 8'h35, 1'b0);
    hold_line(1'b1, 2 * CPB);
    compare_all("t3_idle");

    // T4: 0.3-bit glitch, then '1'.
    hold_line(1'b0, (3 * CPB) / 10);
    hold_line(1'b1, 2 * CPB);
    compare_all("t4_glitch");
    apply_frame("t4", 8'h31, 1'b1);
    hold_line(1'b1, CPB);

    // Break: line held low for many bit times gives one framing error.
    hold_line(1'b0, 30 * CPB);
    exp_fe++;
    compare_all("break_low");
    hold_line(1'b1, 2 * CPB);
    compare_all("break_end");
    apply_frame("after_break", 8'h34, 1'b1);
    hold_line(1'b1, CPB);

    // T5: reset in the middle of bit 4 of '6', then '2'.
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(logic'(8'h36 >> i), CPB);
    hold_line(logic'(8'h36 >> 4), CPB / 2);
    rst = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    exp_color = 3'd0;
    exp_byte  = 8'h00;
    compare_all("t5_reset");
    @(negedge clk);
    rst = 1'b0;
    hold_line(1'b1, 2 * CPB);
    compare_all("t5_after");
    apply_frame("t5", 8'h32, 1'b1);
    hold_line(1'b1, CPB);

    // T6: all 256 values in random order with random gaps (zero gap = back-to-back).
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    dr_before = cnt_dr;
    ce_before = cnt_ce;
    fe_before = cnt_fe;
    for (int i = 0; i < 256; i++) begin
      apply_frame($sformatf("t6[%0h]", order[i]), order[i], 1'b1);
      hold_line(1'b1, $urandom_range(2 * CPB, 0));
    end
    hold_line(1'b1, 2 * CPB);
    check("t6.n_dr_total", 32'(cnt_dr - dr_before), 32'd8);
    check("t6.n_ce_total", 32'(cnt_ce - ce_before), 32'd248);
    check("t6.n_fe_total", 32'(cnt_fe - fe_before), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
